// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: datapath width, ALU op codes and
// the arbiter state encodings.
package alu_arbiter_pkg;

  localparam int WORD_SIZE_DEF = 16;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_SLT   = 3'd5;
  localparam logic [2:0] ALU_SHIFT = 3'd6;
  localparam logic [2:0] ALU_MUL   = 3'd7;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i searching upward
// from last_i+1, wrapping modulo NUM_REQ.
module alu_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int GW      = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GW-1:0]      last_i,
  output logic [GW-1:0]      grant_o,
  output logic               any_o
);

  logic [GW-1:0] idx;

  // Offset NUM_REQ revisits last_i itself, so a lone requester is never skipped.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = GW'((int'(last_i) + i) % NUM_REQ);
      if (!any_o && req_i[idx]) begin
        any_o   = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU among NUM_REQ requesters: round-robin accept,
// operand capture, fixed-latency sequencing and a held, per-requester response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ALU_LATENCY = 1,
  parameter int WORD_SIZE   = WORD_SIZE_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [3*NUM_REQ-1:0]           req_op,
  input  logic [WORD_SIZE*NUM_REQ-1:0]   req_in1,
  input  logic [WORD_SIZE*NUM_REQ-1:0]   req_in2,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [WORD_SIZE-1:0]           rsp_data,
  output logic [2:0]                     alu_op,
  output logic [WORD_SIZE-1:0]           alu_in1,
  output logic [WORD_SIZE-1:0]           alu_in2,
  input  logic [WORD_SIZE-1:0]           alu_out,
  output logic                           busy,
  output arb_state_e                     dbg_state
);

  // Handshakes: a request transfers on a cycle where req_valid[i] && req_ready[i];
  // a result transfers on a cycle where rsp_valid[g] && rsp_ready[g]. Valid never
  // depends on ready; ready of a non-granted requester is ignored.

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  arb_state_e           state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic [2:0]           alu_op_q, alu_op_d;
  logic [WORD_SIZE-1:0] alu_in1_q, alu_in1_d;
  logic [WORD_SIZE-1:0] alu_in2_q, alu_in2_d;

  logic [GW-1:0]        pick_idx;
  logic                 pick_any;

  logic [2:0]           op_arr  [NUM_REQ];
  logic [WORD_SIZE-1:0] in1_arr [NUM_REQ];
  logic [WORD_SIZE-1:0] in2_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
    assign op_arr[i]  = req_op[3*i +: 3];
    assign in1_arr[i] = req_in1[WORD_SIZE*i +: WORD_SIZE];
    assign in2_arr[i] = req_in2[WORD_SIZE*i +: WORD_SIZE];
  end

  alu_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr_pick (
    .req_i   (req_valid),
    .last_i  (last_q),
    .grant_o (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    alu_op_d   = alu_op_q;
    alu_in1_d  = alu_in1_q;
    alu_in2_d  = alu_in2_q;
    req_ready  = '0;
    rsp_valid  = '0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          req_ready = onehot(pick_idx);
          grant_d   = pick_idx;
          alu_op_d  = op_arr[pick_idx];
          alu_in1_d = in1_arr[pick_idx];
          alu_in2_d = in2_arr[pick_idx];
          cnt_d     = CW'(ALU_LATENCY);
          state_d   = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        // One extra cycle beyond the latency lets the ALU see the captured operands.
        if (cnt_q == '0) begin
          rsp_data_d = alu_out;
          state_d    = ARB_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ARB_RESP: begin
        rsp_valid = onehot(grant_q);
        if (rsp_ready[grant_q]) begin
          last_d  = grant_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      last_q     <= GW'(NUM_REQ - 1);
      cnt_q      <= '0;
      rsp_data_q <= '0;
      alu_op_q   <= '0;
      alu_in1_q  <= '0;
      alu_in2_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      alu_op_q   <= alu_op_d;
      alu_in1_q  <= alu_in1_d;
      alu_in2_q  <= alu_in2_d;
    end
  end

  assign rsp_data  = rsp_data_q;
  assign alu_op    = alu_op_q;
  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign busy      = (state_q != ARB_IDLE);
  assign dbg_state = state_q;

endmodule
